uart_rx_os: RTL and testbench

Oversampling UART receiver: consumes the one-cycle-wide sample tick (`max_tick`) from a mod-M counter running at 16x the baud rate and recovers 8N1-style serial frames into parallel bytes. Sits directly downstream of the baud-rate mod-M counter. Feeds a FIFO or interface block that accepts one byte per `rx_done_tick`.

---
 rtl/uart_rx_os.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_os.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver driven by a 16x-baud sample tick; recovers start+DBIT(+parity)+stop frames.
// Optional parity stage is compiled in with `define UART_RX_PARITY_EN (adds parameter PARITY_ODD).
module uart_rx_os #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err,
  output logic            busy
);

  localparam int SW = (SB_TICK > 16) ? 5 : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          r_state;
  logic            r_rx_meta;
  logic            r_rx_s;
  logic [SW-1:0]   r_s;
  logic [NW-1:0]   r_n;
  logic [DBIT-1:0] r_b;
  logic [DBIT-1:0] r_dout;
  logic            r_done;
  logic            r_frame_err;
  logic            r_busy;
`ifdef UART_RX_PARITY_EN
  logic            r_p;
  logic            r_par_bad;
  logic            r_parity_err;
`endif

  // NOTE: synchronizer flops reset to the idle line level (1) so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_s         <= '0;
      r_n         <= '0;
      r_b         <= '0;
      r_dout      <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_p          <= 1'b0;
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      // NOTE: default-low every cycle makes the done flag a single-clk pulse even with back-to-back ticks.
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state <= S_START;
            r_s     <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (s_tick) begin
            if (r_s == SW'(7)) begin
              if (!r_rx_s) begin
                r_state <= S_DATA;
                r_s     <= '0;
                r_n     <= '0;
`ifdef UART_RX_PARITY_EN
                r_p     <= 1'b0;
`endif
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end
        S_DATA: begin
          if (s_tick) begin
            if (r_s == SW'(15)) begin
              r_s <= '0;
              r_b <= {r_rx_s, r_b[DBIT-1:1]};
`ifdef UART_RX_PARITY_EN
              r_p <= r_p ^ r_rx_s;
`endif
              if (r_n == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                r_state <= S_PARITY;
`else
                r_state <= S_STOP;
`endif
              end else begin
                r_n <= r_n + NW'(1);
              end
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (s_tick) begin
            if (r_s == SW'(15)) begin
              r_s       <= '0;
              r_par_bad <= r_p ^ r_rx_s ^ PARITY_ODD;
              r_state   <= S_STOP;
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end
`endif
        S_STOP: begin
          if (s_tick) begin
            if (r_s == SW'(SB_TICK - 1)) begin
              r_done      <= 1'b1;
              r_dout      <= r_b;
              r_frame_err <= ~r_rx_s;
`ifdef UART_RX_PARITY_EN
              r_parity_err <= r_par_bad;
`endif
              r_state     <= S_IDLE;
              r_busy      <= 1'b0;
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dout         = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_frame_err;
  assign busy         = r_busy;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = r_parity_err;
`else
  assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: s_tick every 4 clk (64 clk per bit); expected frames queued at send time.
module tb_uart_rx_os;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_LIVE = 1'b1;
`else
  localparam bit PAR_LIVE = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } rec_t;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_tick  = 1'b0;
  logic       rx      = 1'b1;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  rec_t exp_q[$];
  rec_t got_q[$];
  int   pulse_cnt  = 0;
  int   double_cnt = 0;
  logic prev_done  = 1'b0;
  int   errors     = 0;
  int   checks     = 0;
  logic [1:0] tick_cnt = 2'd0;

  uart_rx_os dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_tick       (s_tick),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .parity_err   (parity_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tick_cnt <= tick_cnt + 2'd1;
    s_tick   <= (tick_cnt == 2'd3);
  end

  // Output monitor: captures every completed frame and flags pulses wider than one clk.
  always @(negedge clk) begin
    if (rx_done_tick) begin
      pulse_cnt = pulse_cnt + 1;
      got_q.push_back('{data: dout, fe: frame_err, pe: parity_err});
      if (prev_done) double_cnt = double_cnt + 1;
    end
    prev_done = rx_done_tick;
  end

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit bad_stop, input bit flip_par);
    drive(1'b0, 64);
    for (int i = 0; i < 8; i++) drive(d[i], 64);
    if (PAR_LIVE) drive((^d) ^ flip_par, 64);
    if (bad_stop) begin
      drive(1'b0, 48);
      drive(1'b1, 16);
    end else begin
      drive(1'b1, 64);
    end
  endtask

  task automatic send_expect(input logic [7:0] d, input bit bad_stop, input bit flip_par);
    exp_q.push_back('{data: d, fe: bad_stop, pe: PAR_LIVE & flip_par});
    send_byte(d, bad_stop, flip_par);
  endtask

  task automatic check_frames(input string name, input int n_exp, input int pc0);
    rec_t e;
    rec_t g;
    for (int k = 0; k < 2000 && got_q.size() < n_exp; k++) @(negedge clk);
    checks++;
    if (pulse_cnt - pc0 != n_exp) begin
      errors++;
      $display("FAIL %s pulses: got %0d expected %0d", name, pulse_cnt - pc0, n_exp);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s missing frame: got none expected data=%02h", name, e.data);
      end else begin
        g = got_q.pop_front();
        checks++;
        if (g.data !== e.data) begin
          errors++;
          $display("FAIL %s dout: got %02h expected %02h", name, g.data, e.data);
        end
        checks++;
        if (g.fe !== e.fe) begin
          errors++;
          $display("FAIL %s frame_err: got %b expected %b", name, g.fe, e.fe);
        end
        checks++;
        if (g.pe !== e.pe) begin
          errors++;
          $display("FAIL %s parity_err: got %b expected %b", name, g.pe, e.pe);
        end
      end
    end
    got_q.delete();
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  task automatic test_reset();
    int pc0;
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (dout !== 8'h00) begin
      errors++;
      $display("FAIL reset dout: got %02h expected 00", dout);
    end
    check_bit("reset rx_done_tick", rx_done_tick, 1'b0);
    check_bit("reset frame_err", frame_err, 1'b0);
    check_bit("reset parity_err", parity_err, 1'b0);
    check_bit("reset busy", busy, 1'b0);
    reset_n = 1'b1;
    pc0 = pulse_cnt;
    repeat (2000) @(negedge clk);
    checks++;
    if (pulse_cnt != pc0) begin
      errors++;
      $display("FAIL idle pulses: got %0d expected 0", pulse_cnt - pc0);
    end
  endtask

  task automatic test_normal();
    int pc0 = pulse_cnt;
    send_expect(8'hA5, 1'b0, 1'b0);
    check_frames("normal", 1, pc0);
    check_bit("normal busy after", busy, 1'b0);
  endtask

  task automatic test_back_to_back();
    int pc0 = pulse_cnt;
    send_expect(8'h00, 1'b0, 1'b0);
    send_expect(8'hFF, 1'b0, 1'b0);
    check_frames("back_to_back", 2, pc0);
  endtask

  task automatic test_glitch();
    int pc0 = pulse_cnt;
    rx = 1'b0;
    repeat (8) @(negedge clk);
    check_bit("glitch busy rises", busy, 1'b1);
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if (pulse_cnt != pc0) begin
      errors++;
      $display("FAIL glitch pulses: got %0d expected 0", pulse_cnt - pc0);
    end
    checks++;
    if (dout !== 8'hFF) begin
      errors++;
      $display("FAIL glitch dout: got %02h expected ff", dout);
    end
    check_bit("glitch busy idle", busy, 1'b0);
  endtask

  task automatic test_frame_err();
    int pc0 = pulse_cnt;
    send_expect(8'h3C, 1'b1, 1'b0);
    repeat (100) @(negedge clk);
    check_frames("frame_err", 1, pc0);
    check_bit("frame_err held", frame_err, 1'b1);
    check_bit("frame_err busy idle", busy, 1'b0);
    pc0 = pulse_cnt;
    send_expect(8'h11, 1'b0, 1'b0);
    check_frames("frame_err clear", 1, pc0);
    check_bit("frame_err cleared", frame_err, 1'b0);
  endtask

  task automatic test_reset_mid();
    int pc0 = pulse_cnt;
    logic [7:0] d = 8'h5A;
    drive(1'b0, 64);
    for (int i = 0; i < 4; i++) drive(d[i], 64);
    drive(d[4], 32);
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid dout: got %02h expected 00", dout);
    end
    check_bit("reset_mid rx_done_tick", rx_done_tick, 1'b0);
    check_bit("reset_mid frame_err", frame_err, 1'b0);
    check_bit("reset_mid parity_err", parity_err, 1'b0);
    check_bit("reset_mid busy", busy, 1'b0);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    checks++;
    if (pulse_cnt != pc0) begin
      errors++;
      $display("FAIL reset_mid pulses: got %0d expected 0", pulse_cnt - pc0);
    end
    pc0 = pulse_cnt;
    send_expect(8'h81, 1'b0, 1'b0);
    check_frames("after_reset", 1, pc0);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int pc0 = pulse_cnt;
    send_expect(8'h07, 1'b0, 1'b0);
    check_frames("parity good", 1, pc0);
    pc0 = pulse_cnt;
    send_expect(8'h07, 1'b0, 1'b1);
    check_frames("parity bad", 1, pc0);
    repeat (50) @(negedge clk);
    check_bit("parity_err held", parity_err, 1'b1);
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_normal();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    checks++;
    if (double_cnt != 0) begin
      errors++;
      $display("FAIL pulse width: got %0d wide pulses expected 0", double_cnt);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
